// File: rtl/ahb_bram_bridge_if.sv
// AHB-Lite slave port plus Block RAM port bundle for ahb_bram_bridge.
// slave modport is the bridge view; master modport is the bus/RAM environment view.
interface ahb_bram_bridge_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic [ADDR_WIDTH-1:0] BRAM_RDADDR;
  logic [ADDR_WIDTH-1:0] BRAM_WRADDR;
  logic [31:0]           BRAM_WDATA;
  logic [3:0]            BRAM_WRITE;
  logic [31:0]           BRAM_RDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, BRAM_RDATA,
    output HREADYOUT, HRESP, HRDATA, BRAM_RDADDR, BRAM_WRADDR, BRAM_WDATA, BRAM_WRITE
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, BRAM_RDATA,
    input  HREADYOUT, HRESP, HRDATA, BRAM_RDADDR, BRAM_WRADDR, BRAM_WDATA, BRAM_WRITE
  );
endinterface

// File: rtl/ahb_bram_bridge.sv
// Zero-wait-state AHB-Lite to Block RAM bridge with byte strobes, read-after-write
// forwarding and a two-cycle ERROR response for misaligned or oversize transfers.
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_bram_bridge_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] a);
    return (size == 3'd1 && a[0]) || (size == 3'd2 && a != 2'b00) || (size >= 3'd3);
  endfunction

  function automatic logic [31:0] merge_fwd(input logic [31:0] ram, input logic [31:0] fwd,
                                           input logic [3:0] sel);
    logic [31:0] r;
    r = ram;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = fwd[8*i +: 8];
    return r;
  endfunction

  state_t                state;
  logic                  hreadyout_r;
  logic                  hresp_r;

  logic                  acc_p0;
  logic                  illegal_p0;
  logic                  wr_acc_p0;
  logic                  rd_acc_p0;
  logic                  raw_hit_p0;
  logic [3:0]            mask_p0;
  logic [ADDR_WIDTH-1:0] word_addr_p0;

  logic                  wr_vld_p1;
  logic                  rd_vld_p1;
  logic                  fwd_vld_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [3:0]            wr_mask_p1;
  logic [3:0]            fwd_mask_p1;
  logic [31:0]           fwd_data_p1;
  logic [3:0]            fwd_sel_p1;

  // Bits above the RAM word address alias; NONSEQ and SEQ are treated alike.
  logic                  unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:ADDR_WIDTH+2]};

  // ---- address phase (p0) ----
  assign word_addr_p0 = bus.HADDR[ADDR_WIDTH+1:2];
  assign acc_p0       = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign illegal_p0   = is_illegal(bus.HSIZE, bus.HADDR[1:0]);
  assign mask_p0      = byte_mask(bus.HSIZE, bus.HADDR[1:0]);
  assign wr_acc_p0    = acc_p0 & ~illegal_p0 & bus.HWRITE;
  assign rd_acc_p0    = acc_p0 & ~illegal_p0 & ~bus.HWRITE;
  // The RAM is read-first, so a read of the word being written this cycle returns stale data.
  assign raw_hit_p0   = wr_vld_p1 & (word_addr_p0 == wr_addr_p1);

  assign bus.BRAM_RDADDR = word_addr_p0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      wr_vld_p1   <= 1'b0;
      rd_vld_p1   <= 1'b0;
      fwd_vld_p1  <= 1'b0;
    end else begin
      wr_vld_p1  <= wr_acc_p0;
      rd_vld_p1  <= rd_acc_p0;
      fwd_vld_p1 <= rd_acc_p0 & raw_hit_p0;
      case (state)
        S_IDLE, S_ERR2: begin
          if (acc_p0 && illegal_p0) begin
            state       <= S_ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= 1'b1;
          end else begin
            state       <= S_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_acc_p0) begin
      wr_addr_p1 <= word_addr_p0;
      wr_mask_p1 <= mask_p0;
    end
    if (rd_acc_p0 && raw_hit_p0) begin
      fwd_mask_p1 <= wr_mask_p1;
      fwd_data_p1 <= bus.HWDATA;
    end
  end

  // ---- data phase (p1) ----
  // A write whose data phase lands on a reset cycle is dropped.
  assign bus.BRAM_WRITE  = (wr_vld_p1 && !HRESET) ? wr_mask_p1 : 4'b0000;
  assign bus.BRAM_WRADDR = wr_addr_p1;
  assign bus.BRAM_WDATA  = bus.HWDATA;

  assign fwd_sel_p1  = (rd_vld_p1 && fwd_vld_p1) ? fwd_mask_p1 : 4'b0000;
  assign bus.HRDATA  = merge_fwd(bus.BRAM_RDATA, fwd_data_p1, fwd_sel_p1);

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Scoreboard bench for ahb_bram_bridge: a driver issues AHB transfers and queues the
// hand-computed response; a negedge monitor pops it when the data phase completes.
module tb_ahb_bram_bridge;

  localparam int AW = 14;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [13:0] wa;
    int          waits;
  } exp_t;

  logic HCLK;
  logic HRESET;

  ahb_bram_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single-slave system: the bus-wide ready is this slave's ready.
  assign bus.HREADY = bus.HREADYOUT;

  // Read-first dual-port Block RAM with registered read data.
  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (bus.BRAM_WRITE[i]) mem[bus.BRAM_WRADDR][8*i +: 8] <= bus.BRAM_WDATA[8*i +: 8];
    bus.BRAM_RDATA <= mem[bus.BRAM_RDADDR];
  end

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] wdata_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one address phase and wait until it is accepted (HREADY high).
  task automatic drive(input bit sel, input bit [1:0] trans, input bit w,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    int n;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = w;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HWDATA = wdata_next;
    n = 0;
    @(negedge HCLK);
    while (!bus.HREADY && n < 8) begin
      n++;
      @(negedge HCLK);
    end
    if (!bus.HREADY) begin
      checks++;
      errors++;
      $display("FAIL hready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge HCLK);
    #1;
    if (sel && trans[1] && w) wdata_next = data;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                    input logic [3:0] mask, input logic [13:0] wa);
    q.push_back('{err: 1'b0, rd: 1'b0, data: data, mask: mask, wa: wa, waits: 0});
    drive(1'b1, 2'b10, 1'b1, addr, size, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
    q.push_back('{err: 1'b0, rd: 1'b1, data: exp, mask: 4'h0, wa: 14'h0, waits: 0});
    drive(1'b1, 2'b10, 1'b0, addr, size, 32'h0);
  endtask

  task automatic bad(input bit w, input logic [31:0] addr, input logic [2:0] size);
    q.push_back('{err: 1'b1, rd: !w, data: 32'h0, mask: 4'h0, wa: 14'h0, waits: 1});
    drive(1'b1, 2'b10, w, addr, size, 32'hFFFF_FFFF);
  endtask

  // Monitor: tracks data phases on the bus and scores each completion.
  bit   in_dp = 1'b0;
  int   waits = 0;
  exp_t mon_e;
  always @(negedge HCLK) begin
    if (HRESET) begin
      in_dp = 1'b0;
      waits = 0;
    end else begin
      if (in_dp) begin
        if (!bus.HREADYOUT) begin
          waits++;
          chk("err_wait_hresp", 32'(bus.HRESP), 32'd1);
        end else begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got response expected none at %0t", $time);
          end else begin
            mon_e = q.pop_front();
            chk("wait_states", 32'(waits), 32'(mon_e.waits));
            chk("hresp", 32'(bus.HRESP), 32'(mon_e.err));
            if (mon_e.err) chk("err_no_write", 32'(bus.BRAM_WRITE), 32'd0);
            else if (mon_e.rd) chk("hrdata", bus.HRDATA, mon_e.data);
            else begin
              chk("bram_write", 32'(bus.BRAM_WRITE), 32'(mon_e.mask));
              chk("bram_wraddr", 32'(bus.BRAM_WRADDR), 32'(mon_e.wa));
              chk("bram_wdata", bus.BRAM_WDATA, mon_e.data);
            end
          end
          in_dp = 1'b0;
        end
      end else begin
        chk("stray_write", 32'(bus.BRAM_WRITE), 32'd0);
      end
      if (!in_dp && bus.HSEL && bus.HTRANS[1] && bus.HREADY) begin
        in_dp = 1'b1;
        waits = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET     = 1'b1;
    wdata_next = 32'h0;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HSIZE  = 3'd0;
    bus.HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_bram_write", 32'(bus.BRAM_WRITE), 32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Word write then read back.
    wr(32'h20, 3'd2, 32'hDEAD_BEEF, 4'hF, 14'd8);
    idle();
    rd(32'h20, 3'd2, 32'hDEAD_BEEF);

    // Byte and halfword strobes.
    wr(32'h20, 3'd2, 32'h1122_3344, 4'hF, 14'd8);
    wr(32'h23, 3'd0, 32'hAB00_0000, 4'h8, 14'd8);
    idle();
    rd(32'h20, 3'd2, 32'hAB22_3344);
    wr(32'h22, 3'd1, 32'h7788_0000, 4'hC, 14'd8);
    idle();
    rd(32'h20, 3'd2, 32'h7788_3344);
    wr(32'h21, 3'd0, 32'h0000_CC00, 4'h2, 14'd8);
    idle();
    rd(32'h20, 3'd2, 32'h7788_CC44);

    // Read-after-write: different word (no forwarding), then same word (forwarding).
    wr(32'h40, 3'd2, 32'hAAAA_AAAA, 4'hF, 14'h10);
    wr(32'h44, 3'd2, 32'hAAAA_AAAA, 4'hF, 14'h11);
    idle();
    wr(32'h42, 3'd1, 32'h9988_0000, 4'hC, 14'h10);
    rd(32'h44, 3'd2, 32'hAAAA_AAAA);
    rd(32'h40, 3'd2, 32'h9988_AAAA);
    wr(32'h42, 3'd1, 32'h5566_0000, 4'hC, 14'h10);
    rd(32'h40, 3'd2, 32'h5566_AAAA);
    wr(32'h50, 3'd2, 32'hCAFE_F00D, 4'hF, 14'h14);
    rd(32'h50, 3'd2, 32'hCAFE_F00D);
    idle();
    rd(32'h40, 3'd2, 32'h5566_AAAA);

    // Error responses, including a transfer held through ERR1 and taken in ERR2.
    bad(1'b0, 32'h21, 3'd2);
    bad(1'b1, 32'h20, 3'd3);
    bad(1'b1, 32'h41, 3'd1);
    rd(32'h20, 3'd2, 32'h7788_CC44);
    idle();

    // Address aliasing above the RAM size and a deselected write.
    wr(32'h0001_0060, 3'd2, 32'h600D_F00D, 4'hF, 14'h18);
    idle();
    drive(1'b0, 2'b10, 1'b1, 32'h60, 3'd2, 32'h0BAD_0BAD);
    idle();
    rd(32'h60, 3'd2, 32'h600D_F00D);

    // Streaming: eight writes then eight reads, one per cycle.
    for (int i = 0; i < 8; i++) wr(32'(i * 4), 3'd2, 32'hA5A5_0000 + 32'(i), 4'hF, 14'(i));
    for (int i = 0; i < 8; i++) rd(32'(i * 4), 3'd2, 32'hA5A5_0000 + 32'(i));
    idle();

    // Reset during a write data phase drops the write.
    wr(32'h30, 3'd2, 32'h1234_5678, 4'hF, 14'h0C);
    idle();
    drive(1'b1, 2'b10, 1'b1, 32'h30, 3'd2, 32'hFFFF_FFFF);
    HRESET     = 1'b1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = wdata_next;
    @(negedge HCLK);
    chk("rst_drop_write", 32'(bus.BRAM_WRITE), 32'd0);
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    chk("rst_mid_write", 32'(bus.BRAM_WRITE), 32'd0);
    chk("rst_mid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_mid_hresp", 32'(bus.HRESP), 32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    rd(32'h30, 3'd2, 32'h1234_5678);
    idle();

    // Reset while in ERR1 returns to OKAY.
    drive(1'b1, 2'b10, 1'b0, 32'h21, 3'd2, 32'h0);
    HRESET     = 1'b1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_err_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_err_hresp", 32'(bus.HRESP), 32'd0);
    idle();
    rd(32'h04, 3'd2, 32'hA5A5_0001);
    idle();
    idle();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
